// File: rtl/rob_commit_pkg.sv
// Shared widths and ROB sizing for the commit stage.
// The helper picks the register index that reaches the register file at retire.
package rob_commit_pkg;

  localparam int unsigned RegBus  = 32;
  localparam int unsigned AddrBus = 32;
  localparam int unsigned InstBus = 32;
  localparam int unsigned RobDepth = 16;
  localparam int unsigned RobTagW  = 4;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZeroReg = 5'd0;

  // An entry without a destination retires against x0 so the regfile write is a no-op.
  function automatic reg_idx_t commit_rd_sel(input reg_idx_t rd, input logic rd_need);
    return rd_need ? rd : ZeroReg;
  endfunction

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation from dispatch, CDB result capture,
// in-order retirement to regfile/LSB and mispredict flush at commit.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned DEPTH = RobDepth,
  parameter int unsigned TAG_W = RobTagW
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dispatch_rob_rdy,
  input  logic [4:0]           dispatch_rd,
  input  logic                 dispatch_rd_in_need,
  input  logic                 dispatch_is_store,
  input  logic [AddrBus-1:0]   dispatch_npc,
  output logic [TAG_W-1:0]     rob_alloc_tag,
  output logic                 rob_full,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [RegBus-1:0]    cdb_value,
  input  logic                 cdb_mispredict,
  input  logic [AddrBus-1:0]   cdb_target,
  output logic                 commit_valid,
  output logic [TAG_W-1:0]     commit_tag,
  output logic [4:0]           commit_rd,
  output logic [RegBus-1:0]    commit_value,
  output logic                 commit_store,
  output logic                 flush,
  output logic [AddrBus-1:0]   flush_pc
);

  localparam logic [TAG_W:0] CountMax  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] CountFull = (TAG_W+1)'(DEPTH - 2);

  // Per-field entry storage, indexed by tag.
  reg_idx_t           rd_q       [DEPTH];
  logic               rd_need_q  [DEPTH];
  logic               store_q    [DEPTH];
  logic [AddrBus-1:0] npc_q      [DEPTH];
  logic [RegBus-1:0]  value_q    [DEPTH];
  logic               mispred_q  [DEPTH];
  logic [AddrBus-1:0] target_q   [DEPTH];

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic alloc_en;
  logic commit_en;
  logic flush_en;
  logic cdb_en;

  // Commit looks only at registered ready, so a CDB to the head never bypasses.
  assign alloc_en  = rdy_in && dispatch_rob_rdy && (count_q < CountMax);
  assign commit_en = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign flush_en  = commit_en && mispred_q[head_q];
  assign cdb_en    = rdy_in && cdb_valid && busy_q[cdb_tag];

  assign rob_alloc_tag = tail_q;
  assign rob_full      = (count_q >= CountFull);

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_en) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_en) begin
        ready_d[cdb_tag] = 1'b1;
      end
      if (commit_en) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
      end
      if (alloc_en) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + TAG_W'(1);
      end
      unique case ({alloc_en, commit_en})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_rd    <= ZeroReg;
      commit_value <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_valid <= commit_en;
      flush        <= flush_en;
      if (commit_en) begin
        commit_tag   <= head_q;
        commit_rd    <= commit_rd_sel(rd_q[head_q], rd_need_q[head_q]);
        commit_value <= value_q[head_q];
        commit_store <= store_q[head_q];
      end
      if (flush_en) begin
        flush_pc <= target_q[head_q];
      end
    end
  end

  // Payload needs no reset: busy/ready gate every read of it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && alloc_en && !flush_en) begin
      rd_q[tail_q]      <= dispatch_rd;
      rd_need_q[tail_q] <= dispatch_rd_in_need;
      store_q[tail_q]   <= dispatch_is_store;
      npc_q[tail_q]     <= dispatch_npc;
    end
    if (!rst_in && cdb_en) begin
      value_q[cdb_tag]   <= cdb_value;
      mispred_q[cdb_tag] <= cdb_mispredict;
      target_q[cdb_tag]  <= cdb_target;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, checked each
// cycle against a queue-based program-order model.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        d_v, d_need, d_st;
  logic [4:0]  d_rd;
  logic [31:0] d_npc;
  logic        c_v, c_mis;
  logic [3:0]  c_tag;
  logic [31:0] c_val, c_tgt;
  logic [3:0]  rob_alloc_tag;
  logic        rob_full;
  logic        commit_valid, commit_store, flush;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .rdy_in              (rdy),
    .dispatch_rob_rdy    (d_v),
    .dispatch_rd         (d_rd),
    .dispatch_rd_in_need (d_need),
    .dispatch_is_store   (d_st),
    .dispatch_npc        (d_npc),
    .rob_alloc_tag       (rob_alloc_tag),
    .rob_full            (rob_full),
    .cdb_valid           (c_v),
    .cdb_tag             (c_tag),
    .cdb_value           (c_val),
    .cdb_mispredict      (c_mis),
    .cdb_target          (c_tgt),
    .commit_valid        (commit_valid),
    .commit_tag          (commit_tag),
    .commit_rd           (commit_rd),
    .commit_value        (commit_value),
    .commit_store        (commit_store),
    .flush               (flush),
    .flush_pc            (flush_pc)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          need;
    bit          st;
    bit          rdy;
    bit          mis;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  bit   e_cv, e_fl, e_st, e_zero;
  int   e_tag;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_pc;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   idx_of_tag[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-order model: the queue front is the oldest in-flight instruction.
  task automatic model_step();
    int   size_pre = q.size();
    int   tail_pre = (m_head + q.size()) % 16;
    bit   fl = 0;
    ent_t e;
    if (rst) begin
      q.delete();
      m_head = 0;
      e_cv = 0; e_fl = 0; e_st = 0; e_tag = 0; e_rd = 0; e_val = 0; e_pc = 0;
      e_zero = 1;
      return;
    end
    e_zero = 0;
    e_cv = 0;
    e_fl = 0;
    if (!rdy) return;
    if (size_pre > 0 && q[0].rdy) begin
      e_cv  = 1;
      e_tag = q[0].tag;
      e_rd  = q[0].need ? q[0].rd : 5'd0;
      e_val = q[0].val;
      e_st  = q[0].st;
      if (q[0].mis) begin
        e_fl = 1;
        e_pc = q[0].tgt;
        q.delete();
        m_head = 0;
        fl = 1;
      end else begin
        void'(q.pop_front());
        m_head = (m_head + 1) % 16;
      end
    end
    if (!fl) begin
      if (c_v) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].tag == int'(c_tag)) begin
            q[i].rdy = 1;
            q[i].val = c_val;
            q[i].mis = c_mis;
            q[i].tgt = c_tgt;
          end
        end
      end
      if (d_v && size_pre < 16) begin
        e.tag = tail_pre; e.rd = d_rd; e.need = d_need; e.st = d_st;
        e.rdy = 0; e.mis = 0; e.val = 0; e.tgt = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    chk("alloc_tag", 32'(rob_alloc_tag), 32'((m_head + q.size()) % 16));
    chk("rob_full", 32'(rob_full), 32'(q.size() >= 14));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    chk("flush", 32'(flush), 32'(e_fl));
    if (e_cv || e_zero) begin
      chk("commit_tag", 32'(commit_tag), 32'(e_tag));
      chk("commit_rd", 32'(commit_rd), 32'(e_rd));
      chk("commit_value", commit_value, e_val);
      chk("commit_store", 32'(commit_store), 32'(e_st));
    end
    if (e_fl || e_zero) chk("flush_pc", flush_pc, e_pc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic disp(input logic [4:0] rd, input bit need, input bit st, input logic [31:0] npc);
    d_v = 1; d_rd = rd; d_need = need; d_st = st; d_npc = npc;
    tick();
    d_v = 0;
  endtask

  task automatic cdb(input int tag, input logic [31:0] v, input bit mis, input logic [31:0] tgt);
    c_v = 1; c_tag = 4'(tag); c_val = v; c_mis = mis; c_tgt = tgt;
    tick();
    c_v = 0; c_mis = 0;
  endtask

  initial begin
    int issued, done, pick;
    int cand[$];
    rst = 1; rdy = 1; d_v = 0; d_rd = 0; d_need = 0; d_st = 0; d_npc = 0;
    c_v = 0; c_mis = 0; c_tag = 0; c_val = 0; c_tgt = 0;

    // Reset and single op
    do_reset();
    chk("rst_alloc_tag", 32'(rob_alloc_tag), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    disp(5'd5, 1, 0, 32'h100);
    chk("single_alloc_next", 32'(rob_alloc_tag), 32'd1);
    cdb(0, 32'hDEAD, 0, 0);
    chk("single_no_bypass", 32'(commit_valid), 32'd0);
    tick();
    chk("single_cv", 32'(commit_valid), 32'd1);
    chk("single_rd", 32'(commit_rd), 32'd5);
    chk("single_val", commit_value, 32'hDEAD);
    tick();
    chk("single_cv_drop", 32'(commit_valid), 32'd0);

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) disp(5'(i + 1), 1, 0, 32'(i));
    cdb(2, 32'h22, 0, 0);
    cdb(1, 32'h11, 0, 0);
    cdb(0, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_cv", 32'(commit_valid), 32'd1);
      chk("ooo_tag", 32'(commit_tag), 32'(i));
    end
    tick();
    chk("ooo_idle", 32'(commit_valid), 32'd0);

    // Mispredict flush with a dispatch in the flush cycle
    do_reset();
    for (int i = 0; i < 4; i++) disp(5'(i + 8), 1, 0, 32'(i * 4));
    cdb(1, 32'hB1, 1, 32'h2000);
    cdb(0, 32'hA0, 0, 0);
    cdb(2, 32'hC2, 0, 0);
    chk("mp_first_tag", 32'(commit_tag), 32'd0);
    c_v = 1; c_tag = 4'd3; c_val = 32'hD3; c_mis = 0;
    disp(5'd9, 1, 0, 32'h300);
    c_v = 0;
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_flush_pc", flush_pc, 32'h2000);
    chk("mp_tag", 32'(commit_tag), 32'd1);
    chk("mp_alloc_zero", 32'(rob_alloc_tag), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("mp_no_more", 32'(commit_valid), 32'd0);

    // Fill to full, then stream 40 more with wrap
    do_reset();
    issued = 0; done = 0;
    for (int i = 0; i < 14; i++) begin
      idx_of_tag[(m_head + q.size()) % 16] = issued;
      disp(5'(issued % 32), 1, 0, 32'(issued));
      issued++;
      if (i == 12) chk("fill_not_full_13", 32'(rob_full), 32'd0);
    end
    chk("fill_full_14", 32'(rob_full), 32'd1);
    chk("fill_alloc_14", 32'(rob_alloc_tag), 32'd14);
    for (int cyc = 0; cyc < 600 && done < 54; cyc++) begin
      d_v = (issued < 54 && q.size() < 14);
      if (d_v) begin
        idx_of_tag[(m_head + q.size()) % 16] = issued;
        d_rd = 5'(issued % 32); d_need = 1; d_st = 0; d_npc = 32'(issued);
        issued++;
      end
      cand.delete();
      for (int i = 0; i < q.size(); i++) if (!q[i].rdy) cand.push_back(q[i].tag);
      c_v = (cand.size() > 0) && ($urandom_range(0, 3) != 0);
      if (c_v) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        c_tag = 4'(pick); c_val = 32'h1000 + 32'(idx_of_tag[pick]); c_mis = 0;
      end
      tick();
      if (commit_valid) begin
        chk("fill_order", commit_value, 32'h1000 + 32'(done));
        done++;
      end
    end
    d_v = 0; c_v = 0;
    chk("fill_all_retired", 32'(done), 32'd54);

    // rd_need=0 retires to x0
    do_reset();
    disp(5'd7, 0, 0, 32'h40);
    cdb(0, 32'h55, 0, 0);
    tick();
    chk("noneed_cv", 32'(commit_valid), 32'd1);
    chk("noneed_rd", 32'(commit_rd), 32'd0);

    // Freeze with a ready head, inputs ignored while frozen
    do_reset();
    disp(5'd3, 1, 1, 32'h44);
    cdb(0, 32'h77, 0, 0);
    rdy = 0; d_v = 1; d_rd = 5'd4; d_need = 1; d_st = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_cv", 32'(commit_valid), 32'd0);
      chk("frz_alloc", 32'(rob_alloc_tag), 32'd1);
    end
    rdy = 1; d_v = 0;
    tick();
    chk("frz_resume_cv", 32'(commit_valid), 32'd1);
    chk("frz_resume_val", commit_value, 32'h77);
    chk("frz_resume_st", 32'(commit_store), 32'd1);

    // Reset mid-stream with a ready head
    for (int i = 0; i < 3; i++) disp(5'(i + 1), 1, 0, 32'(i));
    cdb(1, 32'h99, 0, 0);
    rst = 1; tick(); rst = 0;
    chk("rst_mid_cv", 32'(commit_valid), 32'd0);
    chk("rst_mid_alloc", 32'(rob_alloc_tag), 32'd0);
    chk("rst_mid_full", 32'(rob_full), 32'd0);
    tick();
    chk("rst_mid_after", 32'(commit_valid), 32'd0);

    // Random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      d_v = ($urandom_range(0, 1) == 1) && (q.size() < 16);
      d_rd = 5'($urandom); d_need = 1'($urandom); d_st = 1'($urandom); d_npc = $urandom;
      c_v = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        c_tag = 4'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        c_tag = 4'($urandom);
      c_val = $urandom;
      c_mis = ($urandom_range(0, 11) == 0);
      c_tgt = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: the receiving end of the dispatch stage's ROB interface.
- Allocates one in-order entry per dispatched instruction and returns its tag.
- Captures results broadcast on the CDB.
- Retires entries in program order to the register file and LSB.
- Raises a pipeline flush when a retiring branch was mispredicted.

Parameters:
- DEPTH, 16, number of entries (power of two).
- TAG_W, 4, log2(DEPTH), width of head/tail/tag.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low = freeze
- dispatch_rob_rdy  in  1  allocate request (one-cycle pulse from dispatch)
- dispatch_rd  in  5  destination register
- dispatch_rd_in_need  in  1  instruction writes rd
- dispatch_is_store  in  1  instruction is a store
- dispatch_npc  in  32  instruction PC
- rob_alloc_tag  out  TAG_W  tag of next allocation (= tail, combinational)
- rob_full  out  1  stall request to fetch
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing entry
- cdb_value  in  32  result value
- cdb_mispredict  in  1  branch resolved opposite to prediction
- cdb_target  in  32  correct next PC when mispredicted
- commit_valid  out  1  one-cycle retire pulse
- commit_tag  out  TAG_W  retired entry
- commit_rd  out  5  retired rd; 0 when rd not needed
- commit_value  out  32  retired value
- commit_store  out  1  retired entry is a store; LSB performs its write
- flush  out  1  one-cycle mispredict pulse
- flush_pc  out  32  redirect PC

Behaviour:
- Reset (rst_in=1 at posedge):
  - head=tail=count=0; all busy/ready bits 0.
  - Every registered output 0: commit_*, flush, flush_pc.
  - Reset wins over everything; entries in flight mid-operation are discarded.
- rdy_in=0: head, tail, count and entries hold; commit_valid and flush forced 0 that cycle; CDB and dispatch inputs ignored.
- Circular buffer: head/tail are TAG_W bits and wrap DEPTH-1 -> 0 naturally. Count is TAG_W+1 bits, range 0..DEPTH.
- rob_full = (count >= DEPTH-2), combinational. The two-entry slack covers the one-cycle registered latency between fetch and dispatch.
- Allocate (dispatch_rob_rdy=1, count<DEPTH):
  - Write entry[tail] with busy=1, ready=0, rd, rd_need, is_store, npc.
  - tail+1.
  - Request while count==DEPTH: dropped, no state change (bench flags it as a protocol error).
- CDB (cdb_valid=1, entry[cdb_tag].busy=1): set ready=1, value, mispredict, target. A CDB to a non-busy tag is ignored.
- Commit evaluation each edge, on head:
  - If busy && ready: at that edge register commit_valid=1, commit_tag=head, commit_rd (0 when rd_need=0), commit_value, commit_store. Clear busy; head+1.
  - Otherwise commit_valid=0.
  - At most one retire per cycle.
- Latency:
  - CDB sampled at edge E0 sets ready.
  - Earliest retire is registered at E1; commit_valid is high during the cycle after E1.
  - A CDB to the head entry does not bypass into the same-edge commit decision.
- Mispredict at commit (head ready && mispredict):
  - Same edge: commit_valid=1 (the branch still writes rd, e.g. JALR link), flush=1, flush_pc=target.
  - All busy bits cleared; head=tail=count=0.
  - A dispatch arriving at the same edge is discarded.
  - The cycle after the flush, rob_alloc_tag=0 and rob_full=0.
- Simultaneous allocate + commit (no flush): count unchanged; head and tail both advance.
- Allocate into the slot being freed by commit in the same cycle: legal only when count==DEPTH before the edge, which is excluded by the drop rule; no special case needed.
- Store entries: ready is set by the LSB via the CDB once the address/data are known. commit_store tells the LSB to perform the memory write.

Decomposition:
- Shared constants header (existing one): RegBus, AddrBus, InstBus widths; ROB DEPTH/TAG_W defines; ZERO_REG.
- A single module with no sub-module. Entry storage is per-field register arrays indexed by tag, inside this module; splitting it out gives no reuse benefit.

Test Plan:
- Reset then single op: dispatch rd=5, npc=0x100 (tag 0); CDB tag 0, value 0xDEAD at E0 -> commit_valid with rd=5, value=0xDEAD, tag=0 after E1; count returns 0.
- Out-of-order completion: dispatch tags 0,1,2; CDB order 2,1,0 -> commits occur in order 0,1,2 on three consecutive cycles after tag 0 is ready.
- Fill/wrap: 14 dispatches -> rob_full=1 at count 14. Continue retiring and dispatching 40 instructions -> tags wrap 15->0, no loss, and commit values match the dispatch order.
- Mispredict: tags 0..3 allocated; tag 1 CDB mispredict with target 0x2000, tags 0,2,3 ready. Tag 0 commits, then tag 1 commits with flush=1, flush_pc=0x2000. Tags 2 and 3 never commit; rob_alloc_tag=0 after the flush.
- Simultaneous: allocate while head retires -> count constant. Dispatch pulse in the flush cycle -> discarded. rd_need=0 entry -> commit_rd=0.
- Freeze/reset: rdy_in=0 for 3 cycles with ready head -> no commit, state held, commit on resume. rst_in mid-stream -> all outputs 0 and count=0 at the next edge.
